uart_rx_aux: RTL
================

UART_RX_AUX -- requirements
Module: uart_rx_aux

Interface
REQ-001 Parameter N_DATA_BITS, default 8, number of data bits per frame.
REQ-002 Parameter N_TICKS, default 16, oversampling ticks per bit.
REQ-003 Parameter N_STOP_TICKS, default 16, ticks spent in the stop bit.
REQ-004 Port clock, input, 1, single system clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, reset; synchronous and active-low.
REQ-006 Port ticks, input, 1, one-cycle strobe from the baud generator at BAUD_RATE*N_TICKS.
REQ-007 Port rx, input, 1, asynchronous serial line; idle high.
REQ-008 Port data_out, output, N_DATA_BITS, last correctly framed byte, LSB received first.
REQ-009 Port rx_done, output, 1, one-clock pulse when data_out is updated.
REQ-010 Port frame_error, output, 1, one-clock pulse when the stop bit samples low.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; the FSM uses only the synchronized value rx_s.
REQ-012 FSM states: IDLE, START, DATA, STOP.
REQ-013 Tick counter s: clog2(N_TICKS) bits minimum. Bit counter n: clog2(N_DATA_BITS) bits minimum. Both advance only on clocks with ticks=1.
REQ-014 IDLE: when rx_s=0 (on any clock, tick not required), go to START with s=0.
REQ-015 START: when ticks=1 and s=N_TICKS/2-1, sample rx_s. If 0, go to DATA with s=0, n=0; if 1 (false start), return to IDLE. Otherwise, s increments on each tick.
REQ-016 DATA: when ticks=1 and s=N_TICKS-1, shift rx_s into the MSB of the shift register (right shift) and set s=0. If n=N_DATA_BITS-1, go to STOP; else n increments.
REQ-017 STOP: when ticks=1 and s=N_STOP_TICKS-1, sample rx_s and return to IDLE. If 1, load data_out from the shift register and pulse rx_done. If 0, pulse frame_error and leave data_out unchanged.
REQ-018 rx_done and frame_error SHALL be registered, high for exactly one clock, and never high together.
REQ-019 data_out SHALL hold its value between frames.
REQ-020 Latency: rx_done asserts on the clock after the tick at which stop-bit tick N_STOP_TICKS-1 is accepted.
REQ-021 A frame may start on the first clock after STOP returns to IDLE; back-to-back frames SHALL NOT be lost.
REQ-022 rx activity outside IDLE/START sampling points SHALL be ignored (no resync mid-frame).

Reset
REQ-023 While reset=0 at a clock edge: state=IDLE, s=0, n=0, shift register=0, data_out=0, rx_done=0, frame_error=0, synchronizer=1.
REQ-024 Reset mid-frame SHALL abort the frame with no rx_done or frame_error pulse; reception restarts on the next falling edge after reset deasserts.

Structure
REQ-025 Shared package holds: state encoding (IDLE=0, START=1, DATA=2, STOP=3), the CLK, BAUD_RATE and NUM_TICKS constants, and the default N_DATA_BITS.
REQ-026 No sub-module; the 2-flop synchronizer stays inline. Top-level integration instantiates baud_rate_gen_AUX alongside uart_rx_aux, with ticks wired between them.

Verification
REQ-027 Tick every 4 clocks; send 0xA5 as 8N1 -> one rx_done pulse, data_out=0xA5, frame_error never high.
REQ-028 rx low for 3 ticks then high -> FSM returns to IDLE; no rx_done, no frame_error; data_out unchanged.
REQ-029 Send 0x3C with stop bit held 0 -> one frame_error pulse; no rx_done; data_out keeps its previous value.
REQ-030 Send 0x00, 0xFF and 0x81 back-to-back, each with one stop bit -> three rx_done pulses in order, with data_out 0x00, 0xFF, 0x81.
REQ-031 Assert reset during data bit 4 of 0x55, release it, then send 0x96 -> no pulse for the aborted frame; after reset data_out=0; next rx_done gives data_out=0x96.
REQ-032 Real baud generator (N_CONT=13, 50 MHz, 230400 baud); send 0x5A with line timing off by +2% -> data_out=0x5A, no frame_error.

Source files
------------

// File: rtl/uart_rx_aux_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_aux_pkg
// Purpose : Shared definitions for the auxiliary UART receiver and the baud
//           tick generator that feeds it.
// Contents: rx_state_t  - receiver FSM state encoding
//           CLK, BAUD_RATE, NUM_TICKS - system timing constants
//           DEF_N_DATA_BITS - default data bits per frame
//           BAUD_N_CONT - clocks per oversampling tick for the defaults
//           cnt_width() - counter width helper, never narrower than 1 bit
// ----------------------------------------------------------------------------
package uart_rx_aux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int CLK             = 50_000_000;
  localparam int BAUD_RATE       = 230_400;
  localparam int NUM_TICKS       = 16;
  localparam int DEF_N_DATA_BITS = 8;

  // Integer division rounds down: 50 MHz / (230400 * 16) gives 13.
  localparam int BAUD_N_CONT     = CLK / (BAUD_RATE * NUM_TICKS);

  // Bits needed to count 0..v-1; a single-value counter still gets 1 bit.
  function automatic int cnt_width(input int v);
    int w;
    if (v <= 1) begin
      w = 1;
    end else begin
      w = $clog2(v);
    end
    return w;
  endfunction

endpackage

// File: rtl/baud_rate_gen_aux.sv
// ----------------------------------------------------------------------------
// baud_rate_gen_aux
// Purpose : Free-running modulo-N_CONT counter producing a one-clock tick
//           strobe every N_CONT clocks (BAUD_RATE * NUM_TICKS nominal).
// Ports   : clock - system clock, rising edge
//           reset - synchronous, active-low
//           tick  - registered one-clock strobe
// ----------------------------------------------------------------------------
module baud_rate_gen_aux
  import uart_rx_aux_pkg::*;
#(
  parameter int N_CONT = BAUD_N_CONT
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = cnt_width(N_CONT);
  localparam logic [CW-1:0] C_LAST = CW'(N_CONT - 1);
  localparam logic [CW-1:0] C_ZERO = CW'(0);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider counter and registered tick strobe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt  <= C_ZERO;
      r_tick <= 1'b0;
    end else if (r_cnt == C_LAST) begin
      r_cnt  <= C_ZERO;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + C_ONE;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx_aux.sv
// ----------------------------------------------------------------------------
// uart_rx_aux
// Purpose : Oversampling UART receiver (start bit, N_DATA_BITS LSB first,
//           one stop bit). The line is resynchronised only in IDLE; once a
//           start bit is validated the frame runs to completion on ticks.
// Ports   : clock       - system clock, rising edge
//           reset       - synchronous, active-low
//           ticks       - one-clock strobe at BAUD_RATE * N_TICKS
//           rx          - asynchronous serial input, idle high
//           data_out    - last correctly framed word, held between frames
//           rx_done     - one-clock pulse when data_out is updated
//           frame_error - one-clock pulse when the stop bit samples low
// ----------------------------------------------------------------------------
module uart_rx_aux
  import uart_rx_aux_pkg::*;
#(
  parameter int N_DATA_BITS  = DEF_N_DATA_BITS,
  parameter int N_TICKS      = NUM_TICKS,
  parameter int N_STOP_TICKS = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ticks,
  input  logic                   rx,
  output logic [N_DATA_BITS-1:0] data_out,
  output logic                   rx_done,
  output logic                   frame_error
);

  // The tick counter also times the stop bit, so size it for the larger span.
  localparam int SW = cnt_width((N_TICKS > N_STOP_TICKS) ? N_TICKS : N_STOP_TICKS);
  localparam int NW = cnt_width(N_DATA_BITS);

  localparam logic [SW-1:0] S_ZERO = SW'(0);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_MID  = SW'(N_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(N_TICKS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(N_STOP_TICKS - 1);
  localparam logic [NW-1:0] N_ZERO = NW'(0);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(N_DATA_BITS - 1);
  localparam logic [N_DATA_BITS-1:0] D_ZERO = {N_DATA_BITS{1'b0}};

  logic                   r_rx_meta;
  logic                   r_rx_s;
  rx_state_t              r_state;
  logic [SW-1:0]          r_s;
  logic [NW-1:0]          r_n;
  logic [N_DATA_BITS-1:0] r_shift;
  logic [N_DATA_BITS-1:0] r_data_out;
  logic                   r_rx_done;
  logic                   r_frame_error;

  rx_state_t              w_state_nxt;
  logic [SW-1:0]          w_s_nxt;
  logic [NW-1:0]          w_n_nxt;
  logic [N_DATA_BITS-1:0] w_shift_nxt;
  logic                   w_done_set;
  logic                   w_ferr_set;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State register together with the tick/bit counters and shift register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= S_ZERO;
      r_n     <= N_ZERO;
      r_shift <= D_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_shift_nxt = r_shift;
    case (r_state)
      IDLE: begin
        // Falling edge detection does not wait for a tick.
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = S_ZERO;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (ticks) begin
          if (r_s == S_MID) begin
            if (!r_rx_s) begin
              w_state_nxt = DATA;
              w_s_nxt     = S_ZERO;
              w_n_nxt     = N_ZERO;
            end else begin
              // Glitch shorter than half a bit: treat as noise.
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_nxt = r_s + S_ONE;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (ticks) begin
          if (r_s == S_BIT) begin
            // LSB arrives first, so each new bit enters at the top.
            w_shift_nxt = {r_rx_s, r_shift[N_DATA_BITS-1:1]};
            w_s_nxt     = S_ZERO;
            if (r_n == N_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_n_nxt = r_n + N_ONE;
            end
          end else begin
            w_s_nxt = r_s + S_ONE;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (ticks) begin
          if (r_s == S_STOP) begin
            w_state_nxt = IDLE;
            w_s_nxt     = S_ZERO;
          end else begin
            w_s_nxt = r_s + S_ONE;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_s_nxt     = S_ZERO;
        w_n_nxt     = N_ZERO;
      end
    endcase
  end

  // Frame-completion decode: exactly one of done/error at the stop sample.
  always_comb begin
    w_done_set = 1'b0;
    w_ferr_set = 1'b0;
    if ((r_state == STOP) && ticks && (r_s == S_STOP)) begin
      w_done_set = r_rx_s;
      w_ferr_set = ~r_rx_s;
    end else begin
      w_done_set = 1'b0;
      w_ferr_set = 1'b0;
    end
  end

  // Registered outputs; data_out only changes on a good stop bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_data_out    <= D_ZERO;
      r_rx_done     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_rx_done     <= w_done_set;
      r_frame_error <= w_ferr_set;
      if (w_done_set) begin
        r_data_out <= r_shift;
      end else begin
        r_data_out <= r_data_out;
      end
    end
  end

  assign data_out    = r_data_out;
  assign rx_done     = r_rx_done;
  assign frame_error = r_frame_error;

endmodule
